// File: rtl/output_activation_packer_pkg.sv
// output_activation_packer_pkg: activation types and packing constants shared with the packer
package output_activation_packer_pkg;
    typedef logic signed [7:0] int8_t;
    typedef logic [31:0] act_word_t;
    localparam int ACT_BYTES_PER_WORD = 4;
    localparam logic [7:0] ACT_PAD_BYTE = 8'h80;
endpackage

// File: rtl/output_activation_packer.sv
// output_activation_packer: packs int8 activations four per word, little-endian, into activation RAM writes
module output_activation_packer
    import output_activation_packer_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  int8_t             in_data,
    input  logic              in_last,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output act_word_t         wr_data,
    output logic [3:0]        wr_be
);
    typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;
    state_t state, state_n;
    logic [1:0] cnt;
    act_word_t word;
    logic [3:0] be;
    logic accept, complete, wr_fire;

    // word-completing bytes need the output register free or handing off this cycle
    assign in_ready = state == PACK && ((cnt != 2'd3 && !in_last) || !wr_valid || wr_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && (cnt == 2'd3 || in_last);
    assign wr_fire  = wr_valid && wr_ready;
    assign busy     = state != IDLE;
    assign be       = 4'b1111 >> (2'd3 - cnt);

    genvar g;
    for (g = 0; g < ACT_BYTES_PER_WORD; g++) begin : g_lane
        if (g < ACT_BYTES_PER_WORD - 1) begin : g_fill
            logic [7:0] lane;
            always_ff @(posedge clk) begin
                if (reset) lane <= '0;
                else if (accept && cnt == 2'(g)) lane <= in_data;
            end
            assign word[8*g +: 8] = cnt > 2'(g) ? lane : cnt == 2'(g) ? in_data : ACT_PAD_BYTE;
        end else begin : g_top
            assign word[8*g +: 8] = cnt == 2'(g) ? in_data : ACT_PAD_BYTE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = state == IDLE && start           ? PACK  :
                  state == PACK && accept && in_last ? DRAIN :
                  state == DRAIN && wr_fire         ? IDLE  : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            done     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_be    <= '0;
        end else begin
            done <= state == DRAIN && wr_fire;
            if (complete) cnt <= '0;
            else if (accept) cnt <= cnt + 2'd1;
            if (complete) begin
                wr_valid <= 1'b1;
                wr_data  <= word;
                wr_be    <= be;
            end else if (wr_fire) begin
                wr_valid <= 1'b0;
            end
            if (state == IDLE && start) wr_addr <= base_addr;
            else if (wr_fire) wr_addr <= wr_addr + 1'b1;
        end
    end
endmodule

// File: tb/tb_output_activation_packer.sv
// tb_output_activation_packer: directed runs checked against a word-level packing model
module tb_output_activation_packer;
    import output_activation_packer_pkg::*;
    localparam int ADDR_W = 12;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } wr_t;

    logic clk = 0, reset = 1, start = 0, in_valid = 0, in_last = 0, wr_ready = 1;
    logic [ADDR_W-1:0] base_addr = '0;
    int8_t in_data = '0;
    logic busy, done, in_ready, wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    act_word_t wr_data;
    logic [3:0] wr_be;

    int checks = 0, errors = 0, done_cnt = 0;
    wr_t exp_q[$], log_q[$];
    wr_t exp_w, held;
    logic pend = 0;
    int stalls[8];

    output_activation_packer #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // model: a run of n bytes (values first, first+1, ...) becomes ceil(n/4) words from base
    task automatic push_run(input int base, input int first, input int n);
        for (int w = 0; w * 4 < n; w++) begin
            wr_t e;
            e.addr = ADDR_W'(base + w);
            e.data = '0;
            e.be   = '0;
            for (int k = 0; k < 4; k++) begin
                int idx = w * 4 + k;
                e.data[8*k +: 8] = idx < n ? 8'(first + idx) : 8'h80;
                e.be[k] = idx < n;
            end
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            pend = 0;
        end else begin
            if (pend) begin
                chk("hold_valid", 64'(wr_valid), 64'd1);
                chk("hold_addr", 64'(wr_addr), 64'(held.addr));
                chk("hold_data", 64'(wr_data), 64'(held.data));
                chk("hold_be", 64'(wr_be), 64'(held.be));
            end
            if (done) done_cnt++;
            if (wr_valid && wr_ready) begin
                log_q.push_back('{wr_addr, wr_data, wr_be});
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h be=%0h, want no write", wr_addr, wr_data, wr_be);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(exp_w.addr));
                    chk("wr_data", 64'(wr_data), 64'(exp_w.data));
                    chk("wr_be", 64'(wr_be), 64'(exp_w.be));
                end
            end
            pend = wr_valid && !wr_ready;
            held = '{wr_addr, wr_data, wr_be};
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] base);
        start = 1;
        base_addr = base;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send_bytes(input int first, input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            int st = 0;
            bit ok = 0;
            in_valid = 1;
            in_data = int8_t'(first + i);
            in_last = last && i == n - 1;
            while (!ok) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1;
                end else begin
                    st++;
                    if (st > 100) begin
                        chk("byte_accept_timeout", 64'(st), 64'd0);
                        ok = 1;
                    end
                end
                @(posedge clk); #1;
            end
            if (i < 8) stalls[i] = st;
        end
        in_valid = 0;
        in_last = 0;
    endtask

    task automatic wait_done(input int runs);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("done_count", 64'(done_cnt), 64'(runs));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_wr_be", 64'(wr_be), 64'd0);
        @(posedge clk); #1;
        reset = 0;

        // run 1: start with a byte already valid; that byte must not be taken on the start cycle
        push_run(12'h010, 1, 8);
        in_valid = 1;
        in_data = 8'sd1;
        do_start(12'h010);
        chk("busy_after_start", 64'(busy), 64'd1);
        send_bytes(1, 8, 1);
        wait_done(1);
        chk("t1_w0_addr", 64'(log_q[0].addr), 64'h010);
        chk("t1_w0_data", 64'(log_q[0].data), 64'h04030201);
        chk("t1_w0_be", 64'(log_q[0].be), 64'hf);
        chk("t1_w1_addr", 64'(log_q[1].addr), 64'h011);
        chk("t1_w1_data", 64'(log_q[1].data), 64'h08070605);

        // run 2: partial final word padded with 0x80
        push_run(0, 1, 5);
        do_start(12'h000);
        send_bytes(1, 5, 1);
        wait_done(2);
        chk("t2_w1_data", 64'(log_q[3].data), 64'h80808005);
        chk("t2_w1_be", 64'(log_q[3].be), 64'h1);

        // bytes offered in IDLE are refused
        in_valid = 1;
        in_data = 8'sd99;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_valid = 0;

        // run 3: RAM back-pressure while bytes stream
        wr_ready = 0;
        push_run(12'h100, 1, 8);
        do_start(12'h100);
        fork
            send_bytes(1, 8, 1);
            begin
                repeat (9) @(posedge clk);
                #1 wr_ready = 1;
            end
        join
        chk("t3_stall_b05", 64'(stalls[4]), 64'd0);
        chk("t3_stall_b07", 64'(stalls[6]), 64'd0);
        chk("t3_stall_b08", 64'(stalls[7]), 64'd2);
        wait_done(3);

        // run 4: address wrap
        push_run(12'hfff, 8'h11, 8);
        do_start(12'hfff);
        send_bytes(8'h11, 8, 1);
        wait_done(4);
        chk("t4_addr0", 64'(log_q[log_q.size()-2].addr), 64'hfff);
        chk("t4_addr1", 64'(log_q[log_q.size()-1].addr), 64'h000);

        // run 5: reset after 6 of 8 bytes, then a fresh run
        push_run(12'h050, 1, 4);
        do_start(12'h050);
        send_bytes(1, 6, 0);
        reset = 1;
        @(posedge clk); #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("mid_rst_wr_data", 64'(wr_data), 64'd0);
        chk("mid_rst_wr_be", 64'(wr_be), 64'd0);
        chk("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
        reset = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_no_done", 64'(done_cnt), 64'd4);
        chk("mid_rst_queue", 64'(exp_q.size()), 64'd0);
        push_run(12'h020, 8'h21, 8);
        do_start(12'h020);
        send_bytes(8'h21, 8, 1);
        wait_done(5);

        // run 6: start during PACK is ignored
        push_run(12'h040, 8'h31, 8);
        do_start(12'h040);
        send_bytes(8'h31, 2, 0);
        do_start(12'h300);
        send_bytes(8'h33, 6, 1);
        wait_done(6);
        chk("t6_addr1", 64'(log_q[log_q.size()-1].addr), 64'h041);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
